// File: rtl/module_path_scheduler.sv
// Round-robin, burst-bounded arbiter for a shared 2-input select/register datapath.
// Drives the datapath select and tags the 2-cycle-late output word with valid/owner.
module module_path_scheduler #(
  parameter int unsigned ParamA   = 10,
  parameter int unsigned MaxBurst = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_sel,
  output logic       o_vld_d2,
  output logic       o_owner_d2,
  output logic       o_busy
);

  localparam int unsigned CntW = $clog2(MaxBurst + 1);

  if (MaxBurst < 1 || ParamA < 1) begin : g_param_check
    $error("module_path_scheduler: MaxBurst and ParamA must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        gnt_d;
  logic              sel_d;
  logic              beat;
  logic              own_now;
  logic [1:0]        vld_q;
  logic [1:0]        own_q;

  // State register plus registered grant/select decoded from the next state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      o_gnt   <= 2'b00;
      o_sel   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      o_gnt   <= gnt_d;
      o_sel   <= sel_d;
    end
  end

  // Next-state, burst counter and round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    own_now = (state_q == OWN1);
    beat    = ((state_q == OWN0) && i_req[0]) || ((state_q == OWN1) && i_req[1]);

    case (state_q)
      IDLE: begin
        if (i_req == 2'b11)   state_d = ptr_q ? OWN1 : OWN0;
        else if (i_req[0])    state_d = OWN0;
        else if (i_req[1])    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!i_req[own_now]) begin
          // Owner released: hand over directly if the other side waits
          state_d = i_req[!own_now] ? (own_now ? OWN0 : OWN1) : IDLE;
          ptr_d   = !own_now;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(MaxBurst - 1)) begin
          cnt_d = '0;
          if (i_req[!own_now]) begin
            state_d = own_now ? OWN0 : OWN1;
            ptr_d   = !own_now;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = {state_d == OWN1, state_d == OWN0};
    sel_d = (state_d == OWN0) ? 1'b1 : ((state_d == OWN1) ? 1'b0 : o_sel);
  end

  // Valid/owner shadow of the datapath's two register stages
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q <= 2'b00;
      own_q <= 2'b00;
    end else begin
      vld_q <= {vld_q[0], beat};
      own_q <= {own_q[0], own_now};
    end
  end

  // Busy flag registered from the next state so it lines up with o_gnt
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_busy <= 1'b0;
    else        o_busy <= (state_d != IDLE);
  end

  assign o_vld_d2   = vld_q[1];
  assign o_owner_d2 = own_q[1];

endmodule

// File: tb/tb_module_path_scheduler.sv
// Directed-vector bench for module_path_scheduler; includes a behavioural
// 2-stage select/register datapath to confirm word/owner alignment.
module tb_module_path_scheduler;

  localparam int unsigned W = 10;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_req;
  logic [1:0] o_gnt;
  logic       o_sel, o_vld_d2, o_owner_d2, o_busy;
  logic [1:0] g1;
  logic       s1, v1, ow1, b1;

  int unsigned checks;
  int unsigned errors;
  int unsigned cyc;
  logic [W-1:0] dp1, dp2;

  module_path_scheduler #(.ParamA(W), .MaxBurst(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_gnt(o_gnt), .o_sel(o_sel),
    .o_vld_d2(o_vld_d2), .o_owner_d2(o_owner_d2), .o_busy(o_busy)
  );

  module_path_scheduler #(.ParamA(W), .MaxBurst(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_gnt(g1), .o_sel(s1),
    .o_vld_d2(v1), .o_owner_d2(ow1), .o_busy(b1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] mk(input logic k, input int unsigned c);
    mk = {k, 9'(c)};
  endfunction

  // Datapath model: mux by o_sel, then two register stages
  always @(posedge i_clk) begin
    dp1 <= o_sel ? mk(1'b0, cyc) : mk(1'b1, cyc);
    dp2 <= dp1;
    cyc <= cyc + 1;
  end

  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       vld;
    logic       own;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [1:0] q, input logic [1:0] g,
                              input logic s, input logic v, input logic o, input logic b);
    vec_t e;
    e.rst_n = r; e.req = q; e.gnt = g; e.sel = s; e.vld = v; e.own = o; e.busy = b;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    i_rst  = 1'b0;
    i_req  = 2'b00;

    // Reset held with random requests
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      i_req = 2'($urandom);
      #1;
      chk($sformatf("rst%0d_gnt", i), 32'(o_gnt), 32'(2'b00));
      chk($sformatf("rst%0d_sel", i), 32'(o_sel), 32'(1'b1));
      chk($sformatf("rst%0d_vld", i), 32'(o_vld_d2), 32'(1'b0));
      chk($sformatf("rst%0d_busy", i), 32'(o_busy), 32'(1'b0));
    end

    // Single requester 0, six cycles
    add(1, 2'b01, 2'b00, 1, 0, 0, 0);
    add(1, 2'b01, 2'b01, 1, 0, 0, 1);
    add(1, 2'b01, 2'b01, 1, 0, 0, 1);
    add(1, 2'b01, 2'b01, 1, 1, 0, 1);
    add(1, 2'b01, 2'b01, 1, 1, 0, 1);
    add(1, 2'b01, 2'b01, 1, 1, 0, 1);
    add(1, 2'b00, 2'b01, 1, 1, 0, 1);
    add(1, 2'b00, 2'b00, 1, 1, 0, 0);
    add(1, 2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11, 2'b00, 1, 0, 0, 0);
    // Constant contention, bursts of 4
    add(1, 2'b11, 2'b00, 1, 0, 0, 0);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 1, 0, 1);
    add(1, 2'b11, 2'b01, 1, 1, 0, 1);
    add(1, 2'b11, 2'b10, 0, 1, 0, 1);
    add(1, 2'b11, 2'b10, 0, 1, 0, 1);
    add(1, 2'b11, 2'b10, 0, 1, 1, 1);
    add(1, 2'b11, 2'b10, 0, 1, 1, 1);
    add(1, 2'b11, 2'b01, 1, 1, 1, 1);
    add(1, 2'b11, 2'b01, 1, 1, 1, 1);
    add(1, 2'b11, 2'b01, 1, 1, 0, 1);
    add(0, 2'b11, 2'b00, 1, 0, 0, 0);
    // Early release of requester 0 after two beats
    add(1, 2'b11, 2'b00, 1, 0, 0, 0);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b10, 2'b01, 1, 1, 0, 1);
    add(1, 2'b10, 2'b10, 0, 1, 0, 1);
    add(1, 2'b10, 2'b10, 0, 0, 0, 1);
    add(1, 2'b00, 2'b10, 0, 1, 1, 1);
    add(1, 2'b11, 2'b00, 0, 1, 1, 0);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 1, 0, 1);
    add(0, 2'b11, 2'b00, 1, 0, 0, 0);
    // Async reset during OWN1 beat 2, then contention restarts at 0
    add(1, 2'b10, 2'b00, 1, 0, 0, 0);
    add(1, 2'b10, 2'b10, 0, 0, 0, 1);
    add(0, 2'b10, 2'b00, 1, 0, 0, 0);
    add(1, 2'b11, 2'b00, 1, 0, 0, 0);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 0, 0, 1);
    add(1, 2'b11, 2'b01, 1, 1, 0, 1);

    foreach (vecs[i]) begin
      @(negedge i_clk);
      i_rst = vecs[i].rst_n;
      i_req = vecs[i].req;
      #1;
      chk($sformatf("row%0d_gnt", i), 32'(o_gnt), 32'(vecs[i].gnt));
      chk($sformatf("row%0d_sel", i), 32'(o_sel), 32'(vecs[i].sel));
      chk($sformatf("row%0d_vld", i), 32'(o_vld_d2), 32'(vecs[i].vld));
      chk($sformatf("row%0d_busy", i), 32'(o_busy), 32'(vecs[i].busy));
      if (vecs[i].vld || !vecs[i].rst_n)
        chk($sformatf("row%0d_owner", i), 32'(o_owner_d2), 32'(vecs[i].own));
      if (vecs[i].vld && vecs[i].rst_n)
        chk($sformatf("row%0d_data", i), 32'(dp2), 32'(mk(vecs[i].own, cyc - 2)));
    end

    // MaxBurst=1 alternates grant every beat under contention
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req = 2'b11;
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("mb1_c0_gnt", 32'(g1), 32'(2'b00));
    for (int i = 1; i <= 6; i++) begin
      @(negedge i_clk);
      #1;
      chk($sformatf("mb1_c%0d_gnt", i), 32'(g1), (i % 2 == 1) ? 32'(2'b01) : 32'(2'b10));
      if (i >= 3) begin
        chk($sformatf("mb1_c%0d_vld", i), 32'(v1), 32'(1'b1));
        chk($sformatf("mb1_c%0d_owner", i), 32'(ow1), (i % 2 == 1) ? 32'(1'b0) : 32'(1'b1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
